// File: rtl/fhe_fifo_pkg.sv
// Shared types for the multi-poly slot FIFO.
// Slot-side FSM state encodings used by the controller.
package fhe_fifo_pkg;

    typedef enum logic {
        WR_IDLE,
        WR_OPEN
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_OPEN
    } rd_state_t;

    function automatic int poly_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/poly_ram_block.sv
// Dual-port line RAM holding one polynomial.
// Each port reads before it writes on the same edge.
module poly_ram_block #(
    parameter int DW = 128,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          we_a_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [DW-1:0] d_a_i,
    output logic [DW-1:0] q_a_o,
    input  logic          we_b_i,
    input  logic [AW-1:0] addr_b_i,
    input  logic [DW-1:0] d_b_i,
    output logic [DW-1:0] q_b_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        q_a_o <= mem_q[addr_a_i];
        q_b_o <= mem_q[addr_b_i];
        if (we_a_i) mem_q[addr_a_i] <= d_a_i;
        if (we_b_i) mem_q[addr_b_i] <= d_b_i;
    end

endmodule

// File: rtl/poly_slot_ctrl.sv
// Slot pointer pair, writer/reader FSMs, occupancy and sticky error flags.
// The open write slot only becomes visible to the reader at commit.
module poly_slot_ctrl
    import fhe_fifo_pkg::*;
#(
    parameter int PTRW = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush_i,
    input  logic            wr_begin_i,
    input  logic            wr_done_i,
    input  logic            rd_begin_i,
    input  logic            rd_done_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [PTRW:0]   count_o,
    output logic            err_ovf_o,
    output logic            err_udf_o,
    output logic            wr_busy_o,
    output logic            rd_busy_o,
    output logic [PTRW-1:0] wr_slot_o,
    output logic [PTRW-1:0] rd_slot_o
);

    logic [PTRW:0] wr_ptr_q, rd_ptr_q;
    wr_state_t     wr_state_q;
    rd_state_t     rd_state_q;
    logic          err_ovf_q, err_udf_q;

    assign full_o  = (wr_ptr_q[PTRW-1:0] == rd_ptr_q[PTRW-1:0]) &&
                     (wr_ptr_q[PTRW] != rd_ptr_q[PTRW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign err_ovf_o = err_ovf_q;
    assign err_udf_o = err_udf_q;
    assign wr_busy_o = (wr_state_q == WR_OPEN);
    assign rd_busy_o = (rd_state_q == RD_OPEN);
    assign wr_slot_o = wr_ptr_q[PTRW-1:0];
    assign rd_slot_o = rd_ptr_q[PTRW-1:0];

    always_ff @(posedge clk) begin
        if (!rstn || flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
        end else begin
            unique case (wr_state_q)
                WR_IDLE: begin
                    if (wr_begin_i) begin
                        if (full_o) err_ovf_q  <= 1'b1;
                        else        wr_state_q <= WR_OPEN;
                    end
                end
                WR_OPEN: begin
                    if (wr_done_i) begin
                        wr_state_q <= WR_IDLE;
                        wr_ptr_q   <= wr_ptr_q + 1'b1;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (rd_begin_i) begin
                        if (empty_o) err_udf_q  <= 1'b1;
                        else         rd_state_q <= RD_OPEN;
                    end
                end
                RD_OPEN: begin
                    if (rd_done_i) begin
                        rd_state_q <= RD_IDLE;
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/poly_slot_fifo_mc.sv
// Multi-poly slot FIFO: one slot holds a whole RLWE ciphertext.
// Each poly RAM is steered to the writer while it owns that slot, else to the reader.
module poly_slot_fifo_mc
    import fhe_fifo_pkg::*;
#(
    parameter int BIT_WIDTH     = 64,
    parameter int LINE_SIZE     = 2,
    parameter int ADDR_WIDTH    = 9,
    parameter int NUM_POLY      = 2,
    parameter int POINTER_WIDTH = 2,
    localparam int FIFO_DEPTH   = 2**POINTER_WIDTH,
    localparam int DW           = BIT_WIDTH*LINE_SIZE,
    localparam int PW           = poly_sel_w(NUM_POLY)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [POINTER_WIDTH:0] count,
    output logic                   err_ovf,
    output logic                   err_udf,
    input  logic                   wr_begin,
    input  logic                   wr_done,
    input  logic                   wr_en,
    input  logic [PW-1:0]          wr_poly,
    input  logic [ADDR_WIDTH-1:0]  wr_addrA,
    input  logic [ADDR_WIDTH-1:0]  wr_addrB,
    input  logic [DW-1:0]          wr_dA,
    input  logic [DW-1:0]          wr_dB,
    output logic [DW-1:0]          wr_qA,
    output logic [DW-1:0]          wr_qB,
    output logic                   wr_busy,
    input  logic                   rd_begin,
    input  logic                   rd_done,
    input  logic                   rd_en,
    input  logic [PW-1:0]          rd_poly,
    input  logic [ADDR_WIDTH-1:0]  rd_addrA,
    input  logic [ADDR_WIDTH-1:0]  rd_addrB,
    output logic [DW-1:0]          rd_dA,
    output logic [DW-1:0]          rd_dB,
    output logic                   rd_valid,
    output logic                   rd_busy
);

    localparam int NRAM = FIFO_DEPTH*NUM_POLY;

    logic [POINTER_WIDTH-1:0] wr_slot, rd_slot;
    logic [POINTER_WIDTH-1:0] wr_slot_q, rd_slot_q;
    logic [PW-1:0]            wr_poly_q, rd_poly_q;
    logic                     rd_valid_q, rd_valid_d;
    logic [DW-1:0]            qa [NRAM];
    logic [DW-1:0]            qb [NRAM];

    poly_slot_ctrl #(.PTRW(POINTER_WIDTH)) u_ctrl (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (flush),
        .wr_begin_i (wr_begin),
        .wr_done_i  (wr_done),
        .rd_begin_i (rd_begin),
        .rd_done_i  (rd_done),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .err_ovf_o  (err_ovf),
        .err_udf_o  (err_udf),
        .wr_busy_o  (wr_busy),
        .rd_busy_o  (rd_busy),
        .wr_slot_o  (wr_slot),
        .rd_slot_o  (rd_slot)
    );

    for (genvar s = 0; s < FIFO_DEPTH; s++) begin : g_slot
        for (genvar p = 0; p < NUM_POLY; p++) begin : g_poly
            logic own_w, we;
            assign own_w = wr_busy && (wr_slot == POINTER_WIDTH'(s));
            assign we    = own_w && wr_en && (wr_poly == PW'(p));
            poly_ram_block #(.DW(DW), .AW(ADDR_WIDTH)) u_ram (
                .clk_i    (clk),
                .we_a_i   (we),
                .addr_a_i (own_w ? wr_addrA : rd_addrA),
                .d_a_i    (wr_dA),
                .q_a_o    (qa[s*NUM_POLY+p]),
                .we_b_i   (we),
                .addr_b_i (own_w ? wr_addrB : rd_addrB),
                .d_b_i    (wr_dB),
                .q_b_o    (qb[s*NUM_POLY+p])
            );
        end
    end

    assign rd_valid_d = rd_en && rd_busy;
    assign rd_valid   = rd_valid_q;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            rd_valid_q <= 1'b0;
            rd_slot_q  <= '0;
            rd_poly_q  <= '0;
            wr_slot_q  <= '0;
            wr_poly_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            wr_slot_q  <= wr_slot;
            wr_poly_q  <= wr_poly;
            if (rd_valid_d) begin
                rd_slot_q <= rd_slot;
                rd_poly_q <= rd_poly;
            end
        end
    end

    // An out-of-range poly select matches no RAM, so it reads as zero.
    always_comb begin
        rd_dA = '0;
        rd_dB = '0;
        wr_qA = '0;
        wr_qB = '0;
        for (int s = 0; s < FIFO_DEPTH; s++) begin
            for (int p = 0; p < NUM_POLY; p++) begin
                if (rd_slot_q == POINTER_WIDTH'(s) && rd_poly_q == PW'(p)) begin
                    rd_dA = qa[s*NUM_POLY+p];
                    rd_dB = qb[s*NUM_POLY+p];
                end
                if (wr_slot_q == POINTER_WIDTH'(s) && wr_poly_q == PW'(p)) begin
                    wr_qA = qa[s*NUM_POLY+p];
                    wr_qB = qb[s*NUM_POLY+p];
                end
            end
        end
    end

endmodule

// File: tb/tb_poly_slot_fifo_mc.sv
// Directed bench for poly_slot_fifo_mc.
// Linear steps with hand-derived expectations.
module tb_poly_slot_fifo_mc;

    logic         clk = 1'b0;
    logic         rstn, flush;
    logic         full, empty, err_ovf, err_udf;
    logic [2:0]   count;
    logic         wr_begin, wr_done, wr_en, wr_busy;
    logic [0:0]   wr_poly;
    logic [8:0]   wr_addrA, wr_addrB;
    logic [127:0] wr_dA, wr_dB, wr_qA, wr_qB;
    logic         rd_begin, rd_done, rd_en, rd_valid, rd_busy;
    logic [0:0]   rd_poly;
    logic [8:0]   rd_addrA, rd_addrB;
    logic [127:0] rd_dA, rd_dB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    poly_slot_fifo_mc dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .full(full), .empty(empty), .count(count),
        .err_ovf(err_ovf), .err_udf(err_udf),
        .wr_begin(wr_begin), .wr_done(wr_done), .wr_en(wr_en),
        .wr_poly(wr_poly), .wr_addrA(wr_addrA), .wr_addrB(wr_addrB),
        .wr_dA(wr_dA), .wr_dB(wr_dB), .wr_qA(wr_qA), .wr_qB(wr_qB),
        .wr_busy(wr_busy),
        .rd_begin(rd_begin), .rd_done(rd_done), .rd_en(rd_en),
        .rd_poly(rd_poly), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .rd_dA(rd_dA), .rd_dB(rd_dB), .rd_valid(rd_valid),
        .rd_busy(rd_busy)
    );

    function automatic logic [127:0] pat(int k, int p, int l, int port);
        return {32'hC0DE0000 + 32'(k), 32'(p), 32'(l), 32'h55 + 32'(port)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 0; flush = 0;
        wr_begin = 0; wr_done = 0; wr_en = 0; wr_poly = 0;
        wr_addrA = 0; wr_addrB = 0; wr_dA = 0; wr_dB = 0;
        rd_begin = 0; rd_done = 0; rd_en = 0; rd_poly = 0;
        rd_addrA = 0; rd_addrB = 0;
        repeat (2) step();
        rstn = 1;
        step();
        chk("rst_count", 128'(count), 0);
        chk("rst_empty", 128'(empty), 1);
        chk("rst_full", 128'(full), 0);
        chk("rst_ovf", 128'(err_ovf), 0);
        chk("rst_udf", 128'(err_udf), 0);
        chk("rst_rdv", 128'(rd_valid), 0);
        chk("rst_busy", 128'({wr_busy, rd_busy}), 0);

        wr_begin = 1; step(); wr_begin = 0;
        chk("w1_busy", 128'(wr_busy), 1);
        chk("w1_cnt_open", 128'(count), 0);
        for (int l = 0; l < 4; l++) begin
            wr_en = 1; wr_poly = 0;
            wr_addrA = 9'(l); wr_addrB = 9'(l + 16);
            wr_dA = pat(0, 0, l, 0); wr_dB = pat(0, 0, l, 1);
            step();
        end
        wr_en = 0; wr_done = 1;
        chk("w1_empty_pre", 128'(empty), 1);
        step(); wr_done = 0;
        chk("w1_count", 128'(count), 1);
        chk("w1_empty", 128'(empty), 0);
        chk("w1_busy_off", 128'(wr_busy), 0);

        rd_begin = 1; step(); rd_begin = 0;
        chk("r1_busy", 128'(rd_busy), 1);
        for (int l = 0; l < 4; l++) begin
            rd_en = 1; rd_poly = 0;
            rd_addrA = 9'(l); rd_addrB = 9'(l + 16);
            step(); rd_en = 0;
            chk("r1_valid", 128'(rd_valid), 1);
            chk("r1_dA", rd_dA, pat(0, 0, l, 0));
            chk("r1_dB", rd_dB, pat(0, 0, l, 1));
            step();
            chk("r1_valid_off", 128'(rd_valid), 0);
        end
        rd_done = 1; step(); rd_done = 0;
        chk("r1_empty", 128'(empty), 1);
        chk("r1_count", 128'(count), 0);

        for (int k = 1; k <= 4; k++) begin
            wr_begin = 1; step(); wr_begin = 0;
            wr_en = 1; wr_poly = 0;
            wr_addrA = 0; wr_addrB = 1;
            wr_dA = pat(k, 0, 0, 0); wr_dB = pat(k, 0, 1, 0);
            step();
            wr_poly = 1;
            wr_dA = pat(k, 1, 0, 0); wr_dB = pat(k, 1, 1, 0);
            step();
            wr_en = 0; wr_done = 1; step(); wr_done = 0;
        end
        chk("fill_full", 128'(full), 1);
        chk("fill_count", 128'(count), 4);
        wr_begin = 1; step(); wr_begin = 0;
        chk("ovf_flag", 128'(err_ovf), 1);
        chk("ovf_busy", 128'(wr_busy), 0);
        chk("ovf_full", 128'(full), 1);

        rd_begin = 1; step(); rd_begin = 0;
        rd_en = 1; rd_poly = 1; rd_addrA = 0; rd_addrB = 1;
        step(); rd_en = 0;
        chk("s0_p1_dA", rd_dA, pat(1, 1, 0, 0));
        chk("s0_p1_dB", rd_dB, pat(1, 1, 1, 0));
        rd_done = 1; step(); rd_done = 0;
        chk("pop_full", 128'(full), 0);
        chk("pop_count", 128'(count), 3);

        rd_begin = 1; step(); rd_begin = 0;
        rd_done = 1; step(); rd_done = 0;
        chk("pop2_count", 128'(count), 2);

        wr_begin = 1; rd_begin = 1; step();
        wr_begin = 0; rd_begin = 0;
        chk("sim_busy", 128'({wr_busy, rd_busy}), 3);
        wr_en = 1; wr_poly = 0; wr_addrA = 0; wr_addrB = 1;
        wr_dA = pat(5, 0, 0, 0); wr_dB = pat(5, 0, 1, 0);
        rd_en = 1; rd_poly = 0; rd_addrA = 0; rd_addrB = 1;
        step(); wr_en = 0; rd_en = 0;
        chk("sim_rd_dA", rd_dA, pat(3, 0, 0, 0));
        wr_done = 1; rd_done = 1;
        chk("sim_cnt_pre", 128'(count), 2);
        step(); wr_done = 0; rd_done = 0;
        chk("sim_cnt", 128'(count), 2);
        chk("sim_idle", 128'({wr_busy, rd_busy}), 0);

        rd_begin = 1; step(); rd_begin = 0;
        rd_en = 1; rd_poly = 0; rd_addrA = 0; rd_addrB = 1;
        step(); rd_en = 0;
        chk("drain_a", rd_dB, pat(4, 0, 1, 0));
        rd_done = 1; step(); rd_done = 0;
        rd_begin = 1; step(); rd_begin = 0;
        rd_en = 1; step(); rd_en = 0;
        chk("drain_b", rd_dA, pat(5, 0, 0, 0));
        rd_done = 1; step(); rd_done = 0;
        chk("drain_empty", 128'(empty), 1);

        rd_begin = 1; step(); rd_begin = 0;
        chk("udf_flag", 128'(err_udf), 1);
        chk("udf_busy", 128'(rd_busy), 0);
        flush = 1; step(); flush = 0;
        chk("fl_udf", 128'(err_udf), 0);
        chk("fl_ovf", 128'(err_ovf), 0);

        for (int k = 10; k < 19; k++) begin
            wr_begin = 1; step(); wr_begin = 0;
            wr_en = 1; wr_poly = 0; wr_addrA = 5; wr_dA = pat(k, 0, 5, 0);
            step();
            wr_poly = 1; wr_dA = pat(k, 1, 5, 0);
            step();
            wr_en = 0; wr_done = 1; step(); wr_done = 0;
            chk("wrap_count", 128'(count), 1);
            rd_begin = 1; step(); rd_begin = 0;
            rd_en = 1; rd_poly = 0; rd_addrA = 5;
            step(); rd_en = 0;
            chk("wrap_p0", rd_dA, pat(k, 0, 5, 0));
            rd_en = 1; rd_poly = 1;
            step(); rd_en = 0;
            chk("wrap_p1", rd_dA, pat(k, 1, 5, 0));
            rd_done = 1; step(); rd_done = 0;
            chk("wrap_empty", 128'(empty), 1);
        end

        wr_begin = 1; step(); wr_begin = 0;
        wr_en = 1; wr_poly = 0; wr_addrA = 3; wr_dA = 128'h5;
        step();
        wr_dA = 128'hA;
        step(); wr_en = 0;
        chk("mac_rbw", wr_qA, 128'h5);
        step();
        chk("mac_new", wr_qA, 128'hA);

        wr_done = 1; step(); wr_done = 0;
        wr_begin = 1; rd_begin = 1; step();
        wr_begin = 0; rd_begin = 0;
        chk("mid_busy", 128'({wr_busy, rd_busy}), 3);
        chk("mid_count", 128'(count), 1);
        flush = 1; step(); flush = 0;
        chk("mid_empty", 128'(empty), 1);
        chk("mid_count0", 128'(count), 0);
        chk("mid_idle", 128'({wr_busy, rd_busy}), 0);
        chk("mid_full", 128'(full), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
